// File: rtl/param_commit_sched_if.sv
// Host-write / param_mem write-port bundle for the commit scheduler.
// The host side (memif) is the master; the scheduler is the slave.
interface param_commit_sched_if #(
    parameter int PARAM_WIDTH      = 36,
    parameter int PARAM_ADDR_WIDTH = 10,
    parameter int FIFO_DEPTH       = 16
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic                        host_wr_en;
    logic [PARAM_ADDR_WIDTH-1:0] host_wr_addr;
    logic [PARAM_WIDTH-1:0]      host_wr_data;
    logic                        host_commit;
    logic                        ovf_clr;
    logic                        param_wr_en;
    logic [PARAM_ADDR_WIDTH-1:0] param_wr_addr;
    logic [PARAM_WIDTH-1:0]      param_wr_data;
    logic [LVL_W-1:0]            fifo_level;
    logic [LVL_W-1:0]            commit_level;
    logic                        overflow;
    logic                        split_commit;

    modport master (
        output host_wr_en, host_wr_addr, host_wr_data, host_commit, ovf_clr,
        input  param_wr_en, param_wr_addr, param_wr_data,
        input  fifo_level, commit_level, overflow, split_commit
    );

    modport slave (
        input  host_wr_en, host_wr_addr, host_wr_data, host_commit, ovf_clr,
        output param_wr_en, param_wr_addr, param_wr_data,
        output fifo_level, commit_level, overflow, split_commit
    );
endinterface

// File: rtl/param_commit_sched.sv
// Queues host parameter writes and releases committed batches to param_mem
// only inside the frame-start commit window, so coefficient sets change atomically.
module param_commit_sched #(
    parameter int PARAM_WIDTH      = 36,
    parameter int PARAM_ADDR_WIDTH = 10,
    parameter int PC_WIDTH         = 11,
    parameter int FIFO_DEPTH       = 16,
    parameter int COMMIT_SLOTS     = 8
) (
    input  logic                dsp_clk,
    input  logic                reset_n,
    input  logic [PC_WIDTH-1:0] pc,
    param_commit_sched_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = PARAM_ADDR_WIDTH + PARAM_WIDTH;
    localparam logic [PC_WIDTH:0] SLOTS   = (PC_WIDTH+1)'(COMMIT_SLOTS);
    localparam logic [PTR_W:0]    PTR_ONE = (PTR_W+1)'(1);

    logic [PTR_W:0]   wp, rp, cp;
    logic [PTR_W:0]   wp_nxt, level, clevel;
    logic             full, push, drop, pop, win, win_end;
    logic [ENT_W-1:0] mem [FIFO_DEPTH];

    // Pointers carry an extra wrap bit, so level can reach FIFO_DEPTH exactly.
    assign level   = wp - rp;
    assign clevel  = cp - rp;
    assign full    = level[PTR_W];
    assign push    = bus.host_wr_en & ~full;
    assign drop    = bus.host_wr_en & full;
    assign wp_nxt  = push ? wp + PTR_ONE : wp;
    assign win     = {1'b0, pc} < SLOTS;
    assign win_end = {1'b0, pc} == SLOTS;
    assign pop     = win & (clevel != '0);

    assign bus.fifo_level   = level;
    assign bus.commit_level = clevel;

    always_ff @(posedge dsp_clk) begin
        if (push) mem[wp[PTR_W-1:0]] <= {bus.host_wr_addr, bus.host_wr_data};
    end

    always_ff @(posedge dsp_clk or negedge reset_n) begin
        if (!reset_n) begin
            wp                <= '0;
            rp                <= '0;
            cp                <= '0;
            bus.param_wr_en   <= 1'b0;
            bus.param_wr_addr <= '0;
            bus.param_wr_data <= '0;
            bus.overflow      <= 1'b0;
            bus.split_commit  <= 1'b0;
        end else begin
            wp              <= wp_nxt;
            bus.param_wr_en <= pop;
            if (pop) begin
                rp <= rp + PTR_ONE;
                {bus.param_wr_addr, bus.param_wr_data} <= mem[rp[PTR_W-1:0]];
            end
            // Commit captures the post-push pointer so a same-cycle write joins the batch.
            if (bus.host_commit) cp <= wp_nxt;

            if (drop)             bus.overflow <= 1'b1;
            else if (bus.ovf_clr) bus.overflow <= 1'b0;

            // No pop happens at pc == COMMIT_SLOTS, so leftover committed work means a split.
            if (win_end && clevel != '0) bus.split_commit <= 1'b1;
            else if (bus.ovf_clr)        bus.split_commit <= 1'b0;
        end
    end
endmodule

// File: tb/tb_param_commit_sched.sv
// Directed bench for param_commit_sched: a queue-level model checked every
// cycle, plus literal expectations for each scenario's write pattern.
module tb_param_commit_sched;
    localparam int PW    = 36;
    localparam int AW    = 10;
    localparam int PCW   = 11;
    localparam int DEPTH = 16;
    localparam int SLOTS = 8;

    logic           dsp_clk = 1'b0;
    logic           reset_n;
    logic [PCW-1:0] pc = '0;

    param_commit_sched_if #(.PARAM_WIDTH(PW), .PARAM_ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) bus ();

    param_commit_sched #(
        .PARAM_WIDTH(PW), .PARAM_ADDR_WIDTH(AW), .PC_WIDTH(PCW),
        .FIFO_DEPTH(DEPTH), .COMMIT_SLOTS(SLOTS)
    ) dut (
        .dsp_clk(dsp_clk),
        .reset_n(reset_n),
        .pc     (pc),
        .bus    (bus.slave)
    );

    always #5 dsp_clk = ~dsp_clk;
    always @(posedge dsp_clk) pc <= pc + 1'b1;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_on      = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t pc=%0d)", name, act, exp, $time, pc);
        end
    endtask

    // Model: queue of pending entries; ccnt = how many at its head are committed.
    typedef struct { logic [AW-1:0] a; logic [PW-1:0] d; } ent_t;
    ent_t          q[$];
    int            ccnt;
    int            sz0;
    logic          m_en, m_ovf, m_split, set_ovf, set_split;
    logic [AW-1:0] m_addr;
    logic [PW-1:0] m_data;

    always @(posedge dsp_clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            ccnt = 0; m_en = 0; m_addr = '0; m_data = '0; m_ovf = 0; m_split = 0;
        end else begin
            sz0       = q.size();
            set_ovf   = 0;
            set_split = (int'(pc) == SLOTS) && (ccnt > 0);
            m_en      = 0;
            if (int'(pc) < SLOTS && ccnt > 0) begin
                m_en   = 1;
                m_addr = q[0].a;
                m_data = q[0].d;
                q.pop_front();
                ccnt--;
            end
            if (bus.host_wr_en) begin
                if (sz0 < DEPTH) q.push_back('{a: bus.host_wr_addr, d: bus.host_wr_data});
                else             set_ovf = 1;
            end
            if (bus.host_commit) ccnt = q.size();
            if (set_ovf)          m_ovf = 1;
            else if (bus.ovf_clr) m_ovf = 0;
            if (set_split)        m_split = 1;
            else if (bus.ovf_clr) m_split = 0;
        end
    end

    typedef struct { int p; int a; logic [PW-1:0] d; } log_t;
    log_t wlog[$];

    always @(negedge dsp_clk) begin
        if (chk_on) begin
            chk("wr_en", 64'(bus.param_wr_en), 64'(m_en));
            if (m_en) begin
                chk("wr_addr", 64'(bus.param_wr_addr), 64'(m_addr));
                chk("wr_data", 64'(bus.param_wr_data), 64'(m_data));
            end
            chk("fifo_level",   64'(bus.fifo_level),   64'(q.size()));
            chk("commit_level", 64'(bus.commit_level), 64'(ccnt));
            chk("overflow",     64'(bus.overflow),     64'(m_ovf));
            chk("split_commit", 64'(bus.split_commit), 64'(m_split));
        end
        if (bus.param_wr_en === 1'b1)
            wlog.push_back('{p: int'(pc), a: int'(bus.param_wr_addr), d: bus.param_wr_data});
    end

    task automatic wait_pc(input int p);
        int n = 0;
        do begin
            @(negedge dsp_clk);
            n++;
        end while (int'(pc) != p && n < 5000);
        chk("wait_pc", 64'(pc), 64'(p));
    endtask

    task automatic host_write(input int a, input logic [PW-1:0] d);
        bus.host_wr_en   = 1'b1;
        bus.host_wr_addr = AW'(a);
        bus.host_wr_data = d;
        @(negedge dsp_clk);
        bus.host_wr_en   = 1'b0;
    endtask

    task automatic commit();
        bus.host_commit = 1'b1;
        @(negedge dsp_clk);
        bus.host_commit = 1'b0;
    endtask

    task automatic clear_flags();
        bus.ovf_clr = 1'b1;
        @(negedge dsp_clk);
        bus.ovf_clr = 1'b0;
    endtask

    initial begin
        reset_n          = 1'b0;
        bus.host_wr_en   = 1'b0;
        bus.host_wr_addr = '0;
        bus.host_wr_data = '0;
        bus.host_commit  = 1'b0;
        bus.ovf_clr      = 1'b0;
        repeat (3) @(negedge dsp_clk);
        reset_n = 1'b1;
        @(negedge dsp_clk);
        chk_on = 1'b1;

        // Reset state
        chk("rst_wr_en", 64'(bus.param_wr_en), 0);
        chk("rst_fifo_level", 64'(bus.fifo_level), 0);
        chk("rst_overflow", 64'(bus.overflow), 0);

        // Atomic batch
        wait_pc(99);
        wlog.delete();
        host_write(5, 36'h0000000AA);
        host_write(6, 36'h0000000BB);
        commit();
        wait_pc(20);
        chk("atomic_n", 64'(wlog.size()), 2);
        chk("atomic_pc0", 64'(wlog[0].p), 1);
        chk("atomic_a0", 64'(wlog[0].a), 5);
        chk("atomic_d0", 64'(wlog[0].d), 64'h0AA);
        chk("atomic_pc1", 64'(wlog[1].p), 2);
        chk("atomic_a1", 64'(wlog[1].a), 6);
        chk("atomic_d1", 64'(wlog[1].d), 64'h0BB);

        // Uncommitted hold, then commit
        wlog.delete();
        wait_pc(100);
        for (int i = 0; i < 3; i++) host_write(10 + i, PW'(32'h300 + i));
        repeat (3) wait_pc(100);
        chk("hold_n", 64'(wlog.size()), 0);
        chk("hold_fifo_level", 64'(bus.fifo_level), 3);
        chk("hold_commit_level", 64'(bus.commit_level), 0);
        commit();
        wait_pc(20);
        chk("hold_drain_n", 64'(wlog.size()), 3);
        for (int i = 0; i < 3; i++) begin
            chk("hold_drain_pc", 64'(wlog[i].p), 64'(i + 1));
            chk("hold_drain_a", 64'(wlog[i].a), 64'(10 + i));
        end

        // Overflow: 17th write dropped, first 16 survive
        wlog.delete();
        wait_pc(100);
        for (int i = 0; i < 17; i++) host_write(100 + i, PW'(i + 1));
        chk("ovf_set", 64'(bus.overflow), 1);
        chk("ovf_fifo_level", 64'(bus.fifo_level), 16);
        clear_flags();
        chk("ovf_clr", 64'(bus.overflow), 0);
        commit();
        wait_pc(20);
        wait_pc(20);
        chk("ovf_drain_n", 64'(wlog.size()), 16);
        for (int i = 0; i < 16; i++) begin
            chk("ovf_drain_a", 64'(wlog[i].a), 64'(100 + i));
            chk("ovf_drain_d", 64'(wlog[i].d), 64'(i + 1));
        end
        chk("ovf_split", 64'(bus.split_commit), 1);
        clear_flags();
        chk("split_clr", 64'(bus.split_commit), 0);

        // Split batch: 12 committed, 8 slots per window
        wlog.delete();
        wait_pc(100);
        for (int i = 0; i < 12; i++) host_write(200 + i, PW'(32'h100 + i));
        commit();
        wait_pc(20);
        chk("split_set", 64'(bus.split_commit), 1);
        chk("split_first_n", 64'(wlog.size()), 8);
        wait_pc(20);
        chk("split_n", 64'(wlog.size()), 12);
        for (int i = 0; i < 12; i++) begin
            chk("split_pc", 64'(wlog[i].p), 64'(i < 8 ? i + 1 : i - 7));
            chk("split_a", 64'(wlog[i].a), 64'(200 + i));
        end
        clear_flags();

        // Simultaneous write + commit on an empty FIFO
        wlog.delete();
        wait_pc(100);
        bus.host_wr_en   = 1'b1;
        bus.host_commit  = 1'b1;
        bus.host_wr_addr = AW'(7);
        bus.host_wr_data = 36'h123456789;
        @(negedge dsp_clk);
        bus.host_wr_en   = 1'b0;
        bus.host_commit  = 1'b0;
        chk("simul_fifo_level", 64'(bus.fifo_level), 1);
        chk("simul_commit_level", 64'(bus.commit_level), 1);
        wait_pc(20);
        chk("simul_n", 64'(wlog.size()), 1);
        chk("simul_pc", 64'(wlog[0].p), 1);
        chk("simul_a", 64'(wlog[0].a), 7);
        chk("simul_d", 64'(wlog[0].d), 64'h123456789);

        // Reset mid-drain
        wait_pc(100);
        for (int i = 0; i < 8; i++) host_write(300 + i, PW'(32'h500 + i));
        commit();
        wlog.delete();
        wait_pc(3);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_wr_en", 64'(bus.param_wr_en), 0);
        chk("rst_mid_wr_addr", 64'(bus.param_wr_addr), 0);
        chk("rst_mid_wr_data", 64'(bus.param_wr_data), 0);
        chk("rst_mid_fifo_level", 64'(bus.fifo_level), 0);
        chk("rst_mid_commit_level", 64'(bus.commit_level), 0);
        repeat (3) @(negedge dsp_clk);
        #2 reset_n = 1'b1;
        wait_pc(20);
        wait_pc(20);
        chk("rst_mid_n", 64'(wlog.size()), 3);
        chk("rst_mid_last_pc", 64'(wlog[2].p), 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
